// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher: word fetches over valid/ready, in-order responses buffered in a FIFO.
// Optional PREFETCH_BYPASS_EN lets a response reach an empty, ready IF stage in the same cycle.
module instruction_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       memRequestValid,
    output logic [31:0]                memRequestAddress,
    input  logic                       memRequestReady,
    input  logic                       memResponseValid,
    input  logic [31:0]                memResponseData,
    input  logic                       redirect,
    input  logic [31:0]                redirectPc,
    output logic                       fetchValid,
    input  logic                       fetchReady,
    output logic [31:0]                fetchPc,
    output logic [31:0]                fetchPc_4,
    output logic [31:0]                fetchInstruction,
    output logic [$clog2(DEPTH+1)-1:0] debug_occupancy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [31:0]   pc_fifo_q    [DEPTH];
    logic [31:0]   pc_fifo_d    [DEPTH];
    logic [31:0]   instr_fifo_q [DEPTH];
    logic [31:0]   instr_fifo_d [DEPTH];
    logic [31:0]   tag_q        [DEPTH];
    logic [31:0]   tag_d        [DEPTH];

    logic [CW:0] committed;
    logic        accept;
    logic        resp_keep;
    logic        pop;
    logic        bypass;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirectPc[1:0];

    // Requests are throttled so buffered plus outstanding words never exceed the FIFO.
    assign committed         = {1'b0, occ_q} + {1'b0, in_flight_q};
    assign memRequestValid   = !reset && (committed < DEPTH_C);
    assign memRequestAddress = fetch_addr_q;
    assign accept            = memRequestValid && memRequestReady;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = !reset && (occ_q == '0) && (drop_q == '0) && !redirect
                    && fetchReady && memResponseValid;
    assign fetchValid       = (occ_q != '0) || bypass;
    assign fetchPc          = bypass ? tag_q[tag_rd_q] : pc_fifo_q[rd_ptr_q];
    assign fetchInstruction = bypass ? memResponseData : instr_fifo_q[rd_ptr_q];
`else
    assign bypass           = 1'b0;
    assign fetchValid       = (occ_q != '0);
    assign fetchPc          = pc_fifo_q[rd_ptr_q];
    assign fetchInstruction = instr_fifo_q[rd_ptr_q];
`endif

    assign fetchPc_4       = fetchPc + 32'd4;
    assign debug_occupancy = occ_q;

    assign resp_keep = memResponseValid && (drop_q == '0) && !redirect && !bypass;
    assign pop       = fetchReady && (occ_q != '0) && !redirect;

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        occ_d        = occ_q;
        in_flight_d  = in_flight_q;
        drop_d       = drop_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        tag_rd_d     = tag_rd_q;
        tag_wr_d     = tag_wr_q;
        pc_fifo_d    = pc_fifo_q;
        instr_fifo_d = instr_fifo_q;
        tag_d        = tag_q;

        if (accept) begin
            tag_d[tag_wr_q] = fetch_addr_q;
            tag_wr_d        = tag_wr_q + PTR_ONE;
            fetch_addr_d    = fetch_addr_q + 32'd4;
        end

        // Every response retires one pc tag, whether it is kept or dropped.
        if (memResponseValid) begin
            tag_rd_d = tag_rd_q + PTR_ONE;
        end

        case ({accept, memResponseValid})
            2'b10:   in_flight_d = in_flight_q + CNT_ONE;
            2'b01:   in_flight_d = in_flight_q - CNT_ONE;
            default: in_flight_d = in_flight_q;
        endcase

        if (resp_keep) begin
            pc_fifo_d[wr_ptr_q]    = tag_q[tag_rd_q];
            instr_fifo_d[wr_ptr_q] = memResponseData;
            wr_ptr_d               = wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({resp_keep, pop})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
        endcase

        if (memResponseValid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_ONE;
        end

        // Redirect squashes everything buffered and everything still owed by memory.
        if (redirect) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            occ_d        = '0;
            fetch_addr_d = align_word(redirectPc);
            drop_d       = in_flight_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= RESET_PC;
            occ_q        <= '0;
            in_flight_q  <= '0;
            drop_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            tag_rd_q     <= '0;
            tag_wr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_fifo_q[i]    <= '0;
                instr_fifo_q[i] <= '0;
                tag_q[i]        <= '0;
            end
        end else begin
            fetch_addr_q <= fetch_addr_d;
            occ_q        <= occ_d;
            in_flight_q  <= in_flight_d;
            drop_q       <= drop_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            tag_rd_q     <= tag_rd_d;
            tag_wr_q     <= tag_wr_d;
            pc_fifo_q    <= pc_fifo_d;
            instr_fifo_q <= instr_fifo_d;
            tag_q        <= tag_d;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Scoreboard bench for instruction_prefetch_queue: in-order memory model with variable latency,
// expected fetch pcs queued at request acceptance and checked at each IF handshake.
module tb_instruction_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clock;
    logic          reset;
    logic          memRequestValid;
    logic [31:0]   memRequestAddress;
    logic          memRequestReady;
    logic          memResponseValid;
    logic [31:0]   memResponseData;
    logic          redirect;
    logic [31:0]   redirectPc;
    logic          fetchValid;
    logic          fetchReady;
    logic [31:0]   fetchPc;
    logic [31:0]   fetchPc_4;
    logic [31:0]   fetchInstruction;
    logic [CW-1:0] debug_occupancy;

    instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock            (clock),
        .reset            (reset),
        .memRequestValid  (memRequestValid),
        .memRequestAddress(memRequestAddress),
        .memRequestReady  (memRequestReady),
        .memResponseValid (memResponseValid),
        .memResponseData  (memResponseData),
        .redirect         (redirect),
        .redirectPc       (redirectPc),
        .fetchValid       (fetchValid),
        .fetchReady       (fetchReady),
        .fetchPc          (fetchPc),
        .fetchPc_4        (fetchPc_4),
        .fetchInstruction (fetchInstruction),
        .debug_occupancy  (debug_occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1);
    end

    int          checks;
    int          errors;
    int          cyc;
    int          last_due;
    int          mem_lat;
    logic        mem_ready;
    logic        last_acc;
    logic        last_resp;
    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] req_log[$];
    int          req_cyc_log[$];
    logic [31:0] fetch_log[$];
    logic [31:0] pc4_log[$];
    int          fetch_cyc_log[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        req_cyc_log.delete();
        fetch_log.delete();
        pc4_log.delete();
        fetch_cyc_log.delete();
    endtask

    // One clock cycle: present memory inputs, observe handshakes, advance to the next falling edge.
    task automatic step();
        logic [31:0] e;
        logic        acc;
        int          due;
        memRequestReady = mem_ready;
        if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            memResponseValid = 1'b1;
            memResponseData  = instr_of(mem_addr_q[0]);
        end else begin
            memResponseValid = 1'b0;
            memResponseData  = 32'h0;
        end
        #1;
        acc = memRequestValid && memRequestReady;
        if (!redirect && fetchValid && fetchReady) begin
            fetch_log.push_back(fetchPc);
            pc4_log.push_back(fetchPc_4);
            fetch_cyc_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fetch_unexpected: got pc %h, expected no fetch", fetchPc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (fetchPc !== e) begin
                    errors++;
                    $display("FAIL fetch_pc: got %h, expected %h", fetchPc, e);
                end
                checks++;
                if (fetchPc_4 !== e + 32'd4) begin
                    errors++;
                    $display("FAIL fetch_pc_4: got %h, expected %h", fetchPc_4, e + 32'd4);
                end
                checks++;
                if (fetchInstruction !== instr_of(e)) begin
                    errors++;
                    $display("FAIL fetch_instr: got %h, expected %h", fetchInstruction, instr_of(e));
                end
            end
        end
        if (redirect) exp_q.delete();
        if (acc) begin
            req_log.push_back(memRequestAddress);
            req_cyc_log.push_back(cyc);
            due = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
            last_due = due;
            mem_addr_q.push_back(memRequestAddress);
            mem_due_q.push_back(due);
            if (!redirect) exp_q.push_back(memRequestAddress);
        end
        if (memResponseValid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        last_acc  = acc;
        last_resp = memResponseValid;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        redirect         = 1'b0;
        redirectPc       = 32'h0;
        fetchReady       = 1'b0;
        mem_ready        = 1'b0;
        memRequestReady  = 1'b0;
        memResponseValid = 1'b0;
        memResponseData  = 32'h0;
        mem_lat          = 1;
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        clear_logs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        cyc      = cyc + 3;
        last_due = cyc;
        reset    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n          = 0;
        mem_ready  = 1'b0;
        fetchReady = 1'b1;
        redirect   = 1'b0;
        while ((exp_q.size() != 0 || mem_addr_q.size() != 0 || fetchValid) && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL drain: %0d entries still expected, fetchValid %b, required empty", exp_q.size(), fetchValid);
        end
        checks++;
        if (debug_occupancy !== '0) begin
            errors++;
            $display("FAIL drain_occupancy: got %0d, expected 0", debug_occupancy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (memRequestValid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, expected 0", memRequestValid); end
        checks++;
        if (memRequestAddress !== RESET_PC) begin errors++; $display("FAIL rst_req_addr: got %h, expected %h", memRequestAddress, RESET_PC); end
        checks++;
        if (fetchValid !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid: got %b, expected 0", fetchValid); end
        checks++;
        if (fetchPc !== 32'h0) begin errors++; $display("FAIL rst_fetch_pc: got %h, expected 0", fetchPc); end
        checks++;
        if (fetchPc_4 !== 32'h4) begin errors++; $display("FAIL rst_fetch_pc_4: got %h, expected 4", fetchPc_4); end
        checks++;
        if (fetchInstruction !== 32'h0) begin errors++; $display("FAIL rst_fetch_instr: got %h, expected 0", fetchInstruction); end
        checks++;
        if (debug_occupancy !== '0) begin errors++; $display("FAIL rst_occupancy: got %0d, expected 0", debug_occupancy); end
        apply_reset();
        #1;
        checks++;
        if (memRequestValid !== 1'b1) begin errors++; $display("FAIL rel_req_valid: got %b, expected 1", memRequestValid); end
        checks++;
        if (memRequestAddress !== RESET_PC) begin errors++; $display("FAIL rel_req_addr: got %h, expected %h", memRequestAddress, RESET_PC); end
    endtask

    task automatic test_stream();
        apply_reset();
        mem_ready  = 1'b1;
        fetchReady = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_log[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL stream_req_addr[%0d]: got %h, expected %h", i, req_log[i], 32'(i * 4));
            end
        end
        checks++;
        if (fetch_cyc_log[0] - req_cyc_log[0] != 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d cycles, expected 2", fetch_cyc_log[0] - req_cyc_log[0]);
        end
        checks++;
        if (fetch_log.size() != 10) begin
            errors++;
            $display("FAIL stream_throughput: got %0d fetches in 12 cycles, expected 10", fetch_log.size());
        end
        drain();
    endtask

    task automatic test_stall();
        apply_reset();
        mem_ready  = 1'b1;
        fetchReady = 1'b0;
        repeat (8) step();
        checks++;
        if (req_log.size() != 4) begin errors++; $display("FAIL stall_req_count: got %0d, expected 4", req_log.size()); end
        checks++;
        if (memRequestValid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b, expected 0", memRequestValid); end
        checks++;
        if (debug_occupancy !== CW'(4)) begin errors++; $display("FAIL stall_occupancy: got %0d, expected 4", debug_occupancy); end
        fetchReady = 1'b1;
        repeat (3) step();
        checks++;
        if (req_log[4] !== 32'h10) begin errors++; $display("FAIL stall_resume_addr: got %h, expected 00000010", req_log[4]); end
        drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetch_log[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL stall_drain_order[%0d]: got %h, expected %h", i, fetch_log[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        apply_reset();
        mem_lat    = 3;
        mem_ready  = 1'b1;
        fetchReady = 1'b1;
        repeat (2) step();
        mem_ready  = 1'b0;
        redirect   = 1'b1;
        redirectPc = 32'h0000_1003;
        step();
        clear_logs();
        redirect  = 1'b0;
        mem_lat   = 1;
        mem_ready = 1'b1;
        step();
        checks++;
        if (req_log[0] !== 32'h0000_1000) begin errors++; $display("FAIL redir_next_req: got %h, expected 00001000", req_log[0]); end
        repeat (5) step();
        drain();
        checks++;
        if (fetch_log[0] !== 32'h0000_1000) begin errors++; $display("FAIL redir_first_pc: got %h, expected 00001000", fetch_log[0]); end
        checks++;
        if (pc4_log[0] !== 32'h0000_1004) begin errors++; $display("FAIL redir_first_pc_4: got %h, expected 00001004", pc4_log[0]); end
    endtask

    task automatic test_redirect_collision();
        apply_reset();
        mem_ready  = 1'b1;
        fetchReady = 1'b1;
        repeat (4) step();
        redirect   = 1'b1;
        redirectPc = 32'h0000_2000;
        step();
        checks++;
        if (!(last_acc && last_resp)) begin
            errors++;
            $display("FAIL collide_setup: accept %b response %b, expected both 1", last_acc, last_resp);
        end
        clear_logs();
        redirect = 1'b0;
        repeat (6) step();
        drain();
        checks++;
        if (req_log[0] !== 32'h0000_2000) begin errors++; $display("FAIL collide_next_req: got %h, expected 00002000", req_log[0]); end
        checks++;
        if (fetch_log[0] !== 32'h0000_2000) begin errors++; $display("FAIL collide_first_pc: got %h, expected 00002000", fetch_log[0]); end
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_ready  = 1'b0;
        fetchReady = 1'b1;
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFF8;
        step();
        clear_logs();
        redirect  = 1'b0;
        mem_ready = 1'b1;
        repeat (3) step();
        drain();
        checks++;
        if (req_log[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req0: got %h, expected fffffff8", req_log[0]); end
        checks++;
        if (req_log[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req1: got %h, expected fffffffc", req_log[1]); end
        checks++;
        if (req_log[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_req2: got %h, expected 00000000", req_log[2]); end
        checks++;
        if (fetch_log[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h, expected fffffffc", fetch_log[1]); end
        checks++;
        if (pc4_log[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc_4: got %h, expected 00000000", pc4_log[1]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fetchReady = 1'b0;
        mem_ready  = 1'b1;
        repeat (3) step();
        mem_ready = 1'b0;
        repeat (2) step();
        checks++;
        if (debug_occupancy !== CW'(3)) begin errors++; $display("FAIL mid_occupancy_pre: got %0d, expected 3", debug_occupancy); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (fetchValid !== 1'b0) begin errors++; $display("FAIL mid_fetch_valid: got %b, expected 0", fetchValid); end
        checks++;
        if (debug_occupancy !== '0) begin errors++; $display("FAIL mid_occupancy: got %0d, expected 0", debug_occupancy); end
        apply_reset();
        #1;
        checks++;
        if (memRequestValid !== 1'b1) begin errors++; $display("FAIL mid_rel_req_valid: got %b, expected 1", memRequestValid); end
        checks++;
        if (memRequestAddress !== RESET_PC) begin errors++; $display("FAIL mid_rel_req_addr: got %h, expected %h", memRequestAddress, RESET_PC); end
        mem_ready  = 1'b1;
        fetchReady = 1'b1;
        repeat (3) step();
        drain();
        checks++;
        if (fetch_log[0] !== RESET_PC) begin errors++; $display("FAIL mid_first_pc: got %h, expected %h", fetch_log[0], RESET_PC); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        cyc              = 0;
        last_due         = 0;
        mem_lat          = 1;
        mem_ready        = 1'b0;
        last_acc         = 1'b0;
        last_resp        = 1'b0;
        redirect         = 1'b0;
        redirectPc       = 32'h0;
        fetchReady       = 1'b0;
        memRequestReady  = 1'b0;
        memResponseValid = 1'b0;
        memResponseData  = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collision();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Instruction-fetch front end that feeds the IF stage of the 5-stage pipeline. It issues sequential word fetches to instruction memory over a valid/ready request channel and buffers in-order responses in a small FIFO. It presents {pc, pc+4, instruction} to the IF stage under a valid/ready handshake. On an ID-stage jump/branch redirect it flushes the queue and discards any responses still in flight.

## Interface
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- memRequestValid  out  1  fetch request present.
- memRequestAddress  out  32  word address of the request; bits [1:0] are always 0.
- memRequestReady  in  1  memory accepts the request this cycle.
- memResponseValid  in  1  response word present; responses return in request order, one per accepted request, ≥1 cycle after acceptance.
- memResponseData  in  32  instruction word.
- redirect  in  1  ID stage jump/branch taken.
- redirectPc  in  32  target; bits [1:0] ignored (forced to 0).
- fetchValid  out  1  head entry valid.
- fetchReady  in  1  IF stage consumes the head entry (low = stall).
- fetchPc  out  32  pc of the head entry.
- fetchPc_4  out  32  fetchPc+4, with 32-bit wrap.
- fetchInstruction  out  32  instruction of the head entry.
- debug_occupancy  out  $clog2(DEPTH+1)  current FIFO entry count.

## Operation
- State: fetchAddress (32), FIFO (DEPTH × {pc, instr}), read and write pointers, occupancy, inFlight count, dropCount. The last three are each $clog2(DEPTH+1) bits wide.
- Request issue: memRequestValid = (occupancy + inFlight < DEPTH); memRequestAddress = fetchAddress.
- Request acceptance (valid && ready):
  - inFlight increments.
  - fetchAddress += 4, wrapping from 32'hFFFF_FFFC to 0.
  - The pc of each request is tracked in a pc-tag queue of DEPTH entries, paired with its response on return.
- Response with dropCount > 0: the response is discarded and dropCount decrements.
- Response with dropCount = 0: the response is written at the write pointer with its pc tag.
- Every response decrements inFlight.
- Pop: fetchValid && fetchReady advances the read pointer.
- Simultaneous push and pop leaves occupancy unchanged.
- Redirect (synchronous, highest priority), effective at the next edge:
  - FIFO emptied: pointers reset, occupancy 0.
  - fetchAddress = {redirectPc[31:2], 2'b00}.
  - dropCount = inFlight after this cycle's accept and response, i.e. a request accepted in the redirect cycle is also dropped.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is a don't-care; the queue is empty afterwards.
- Full: no request is issued while occupancy + inFlight = DEPTH, so the FIFO never overflows.
- Empty: fetchValid = 0; fetchPc, fetchPc_4 and fetchInstruction hold their last values and are don't-care.
- Reset mid-operation: all counters and pointers clear, fetchAddress = RESET_PC; responses to pre-reset requests are the memory's responsibility to squash.

## Timing
- Reset values:
  - memRequestValid = 0 while reset is high.
  - memRequestAddress = RESET_PC.
  - fetchValid = 0, fetchPc = 0, fetchPc_4 = 4, fetchInstruction = 0.
  - debug_occupancy = 0.
- The first cycle after reset deasserts has memRequestValid = 1 with address RESET_PC.
- Outputs are driven combinationally from registered state only; there is no combinational path from memResponse* to fetch* (except under the configuration macro).
- Response-to-fetchValid latency is 1 cycle.
- Redirect-to-first-new-request latency is 1 cycle.
- Sustained throughput is 1 instruction/cycle when memory returns 1/cycle and DEPTH ≥ memory latency + 1.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - When the FIFO is empty, dropCount = 0, redirect = 0, fetchReady = 1 and memResponseValid = 1, the response drives fetch* combinationally in the same cycle and is not written to the FIFO.
  - Response-to-fetchValid latency becomes 0.
- PREFETCH_BYPASS_EN undefined: every response passes through the FIFO, with 1-cycle minimum latency.

## Test plan
- Reset release, memory ready every cycle, 1-cycle response latency, fetchReady = 1:
  - requests go out at 0x0, 0x4, 0x8, …
  - fetchPc sequence 0x0, 0x4, 0x8 appears on consecutive cycles starting 2 cycles after the first request.
- fetchReady held 0, DEPTH = 4:
  - exactly 4 requests are accepted, then memRequestValid = 0.
  - debug_occupancy = 4.
  - after releasing fetchReady, entries drain in order 0x0–0xC and issue resumes at 0x10.
- Redirect with 2 requests in flight, redirectPc = 0x0000_1003:
  - both in-flight responses are discarded.
  - the next request address is 0x1000.
  - the first fetchPc after the redirect is 0x1000, with fetchPc_4 = 0x1004.
- Redirect in the same cycle as a request handshake and a response:
  - both are dropped.
  - no stale instruction ever reaches fetchValid.
- redirectPc = 0xFFFF_FFF8:
  - requests go out at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - fetchPc_4 for 0xFFFF_FFFC is 0.
- Assert reset while the FIFO holds 3 entries:
  - fetchValid = 0 and debug_occupancy = 0 immediately, without waiting for a clock edge.
  - after release, the first request is RESET_PC.
